// File: rtl/stl_pipe_slice.sv
// Elastic pipeline register: STAGES skid-buffered slices with flush.
// Define STL_PIPE_STALL_CNT_EN to build the backpressure cycle counter.
module stl_pipe_slice #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      STAGES    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [31:0]      o_stall_cnt
);

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [WIDTH-1:0] dat [STAGES+1];

    assign vld[0]      = i_valid;
    assign dat[0]      = i_data;
    assign rdy[STAGES] = i_ready;

    assign o_ready = rdy[0];
    assign o_valid = vld[STAGES];
    assign o_data  = dat[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic             mv_q, mv_d;
        logic             sv_q, sv_d;
        logic [WIDTH-1:0] md_q, md_d;
        logic [WIDTH-1:0] sd_q, sd_d;
        logic             push;
        logic             pop;

        assign push = vld[k] & ~sv_q;
        assign pop  = mv_q & rdy[k+1];

        always_comb begin
            mv_d = mv_q;
            sv_d = sv_q;
            md_d = md_q;
            sd_d = sd_q;
            if (i_flush) begin
                mv_d = 1'b0;
                sv_d = 1'b0;
            end else begin
                unique case ({mv_q, sv_q})
                    2'b00: begin
                        if (push) begin
                            mv_d = 1'b1;
                            md_d = dat[k];
                        end
                    end
                    2'b10: begin
                        if (push && pop) begin
                            md_d = dat[k];
                        end else if (push) begin
                            sv_d = 1'b1;
                            sd_d = dat[k];
                        end else if (pop) begin
                            mv_d = 1'b0;
                        end
                    end
                    2'b11: begin
                        if (pop) begin
                            md_d = sd_q;
                            sv_d = 1'b0;
                        end
                    end
                    default: begin
                        // skid-only state cannot be reached
                        mv_d = 1'b0;
                        sv_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                mv_q <= 1'b0;
                sv_q <= 1'b0;
                md_q <= RESET_VAL;
                sd_q <= RESET_VAL;
            end else begin
                mv_q <= mv_d;
                sv_q <= sv_d;
                md_q <= md_d;
                sd_q <= sd_d;
            end
        end

        assign rdy[k]   = ~sv_q;
        assign vld[k+1] = mv_q;
        assign dat[k+1] = md_q;
    end

`ifdef STL_PIPE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (o_valid && !i_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= 32'h0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stl_pipe_slice.sv
// Directed scoreboard bench for stl_pipe_slice, STAGES=2.
module tb_stl_pipe_slice;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q[$];

    stl_pipe_slice #(
        .WIDTH(32),
        .RESET_VAL(RV),
        .STAGES(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_flush(flush),
        .i_valid(valid),
        .o_ready(o_ready),
        .i_data(data),
        .o_valid(o_valid),
        .i_ready(ready),
        .o_data(o_data),
        .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; samples mid-cycle; returns at next posedge+1.
    task automatic tick(input logic v, input logic [31:0] d,
                        input logic r, input logic f, output logic acc);
        valid = v;
        data  = d;
        ready = r;
        flush = f;
        #3;
        if (o_valid && r) begin
            if (q.size() == 0) chk("spurious_out", {31'b0, o_valid}, 32'h0);
            else chk("out_data", o_data, q.pop_front());
        end
        acc = v && o_ready && !f;
        if (f) q.delete();
        else if (acc) q.push_back(d);
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic a;
        int n;
        n = 0;
        while ((q.size() != 0 || o_valid) && n < 20) begin
            tick(1'b0, '0, 1'b1, 1'b0, a);
            n++;
        end
        chk(tag, q.size(), 32'h0);
        chk({tag, "_vld"}, {31'b0, o_valid}, 32'h0);
    endtask

    logic acc;
    int   nacc;

    initial begin
        // reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_data", o_data, RV);
        chk("rst_ready", {31'b0, o_ready}, 32'h1);
        chk("rst_stall", stall_cnt, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single-item latency
        tick(1'b1, 32'hA1, 1'b1, 1'b0, acc);
        chk("lat_acc", {31'b0, acc}, 32'h1);
        chk("lat_v0", {31'b0, o_valid}, 32'h0);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("lat_v1", {31'b0, o_valid}, 32'h1);
        chk("lat_d1", o_data, 32'hA1);
        drain("lat_drain");

        // streaming, full throughput
        for (int i = 1; i <= 8; i++) begin
            chk("stream_rdy", {31'b0, o_ready}, 32'h1);
            tick(1'b1, i, 1'b1, 1'b0, acc);
        end
        chk("stream_pend", q.size(), 32'h2);
        drain("stream_drain");

        // backpressure: fill to capacity of 4
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'h10 + nacc, 1'b0, 1'b0, acc);
            if (acc) nacc++;
        end
        chk("fill_cnt", nacc, 32'h4);
        chk("fill_rdy", {31'b0, o_ready}, 32'h0);
        chk("fill_vld", {31'b0, o_valid}, 32'h1);
        tick(1'b1, 32'h14, 1'b0, 1'b0, acc);
        chk("hold_data", o_data, 32'h10);
        drain("fill_drain");
        chk("fill_rdy_end", {31'b0, o_ready}, 32'h1);

        // flush with three held entries and a concurrent push
        tick(1'b1, 32'h31, 1'b0, 1'b0, acc);
        tick(1'b1, 32'h32, 1'b0, 1'b0, acc);
        tick(1'b1, 32'h33, 1'b0, 1'b0, acc);
        chk("pre_flush_q", q.size(), 32'h3);
        tick(1'b1, 32'h99, 1'b0, 1'b1, acc);
        chk("flush_vld", {31'b0, o_valid}, 32'h0);
        chk("flush_rdy", {31'b0, o_ready}, 32'h1);
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b1, 32'h55, 1'b1, 1'b0, acc);
        chk("post_flush_v0", {31'b0, o_valid}, 32'h0);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("post_flush_v1", {31'b0, o_valid}, 32'h1);
        chk("post_flush_d", o_data, 32'h55);
        drain("flush_drain");

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h70 + i, 1'b1, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, o_valid}, 32'h0);
        chk("mrst_data", o_data, RV);
        chk("mrst_ready", {31'b0, o_ready}, 32'h1);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("mrst_stale", {31'b0, o_valid}, 32'h0);

        // stall counter: 5 cycles of o_valid with i_ready low
        tick(1'b1, 32'hC0, 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b0, 1'b0, acc);
        repeat (5) tick(1'b0, '0, 1'b0, 1'b0, acc);
`ifdef STL_PIPE_STALL_CNT_EN
        chk("stall_5", stall_cnt, 32'h5);
`else
        chk("stall_off", stall_cnt, 32'h0);
`endif
        tick(1'b0, '0, 1'b1, 1'b1, acc);
        chk("stall_fl_vld", {31'b0, o_valid}, 32'h0);
`ifdef STL_PIPE_STALL_CNT_EN
        chk("stall_flush", stall_cnt, 32'h5);
`else
        chk("stall_off_fl", stall_cnt, 32'h0);
`endif
        drain("end_drain");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
